// File: rtl/merge_pass_ctrl_pkg.sv
// Shared types for the merge-pass sequencer: bank select, controller states, default run length.
package merge_pass_ctrl_pkg;

  typedef enum logic {
    PING = 1'b0,
    PONG = 1'b1
  } bank_sel_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ADVANCE = 3'd3,
    ST_DONE    = 3'd4
  } merge_ctrl_state_t;

  localparam int unsigned INIT_RUN_DEFAULT = 2;

endpackage

// File: rtl/merge_pass_ctrl.sv
// Sequences merge passes over ping/pong banks, doubling run length each pass until one run spans the stream.
// All outputs are registered; each pass costs LAUNCH + done-sample + ADVANCE cycles of controller overhead.
module merge_pass_ctrl
  import merge_pass_ctrl_pkg::*;
#(
  parameter int unsigned LEN_W    = 32,
  parameter int unsigned INIT_RUN = INIT_RUN_DEFAULT,
  parameter int unsigned PASS_W   = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_in,
  input  logic [LEN_W-1:0]  stream_len_in,
  input  logic              pass_done_in,
  output logic              pass_start_out,
  output logic [LEN_W-1:0]  run_len_out,
  output logic              pingpong_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              result_bank_out,
  output logic [PASS_W-1:0] pass_count_out
);

  localparam logic [LEN_W-1:0] INIT_RUN_L = LEN_W'(INIT_RUN);

  merge_ctrl_state_t state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  run_len_q, run_len_d;
  logic              pingpong_q, pingpong_d;
  logic [PASS_W-1:0] pass_count_q, pass_count_d;
  bank_sel_t         result_q, result_d;
  logic              pass_start_q, pass_start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [LEN_W:0]    run_dbl;
  logic [LEN_W-1:0]  run_next;

  // Doubling is done one bit wider so an overflow saturates instead of wrapping to a small run.
  assign run_dbl  = {run_len_q, 1'b0};
  assign run_next = run_dbl[LEN_W] ? {LEN_W{1'b1}} : run_dbl[LEN_W-1:0];

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    run_len_d    = run_len_q;
    pingpong_d   = pingpong_q;
    pass_count_d = pass_count_q;
    result_d     = result_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        // A coincident pass_done_in is deliberately dropped here.
        if (start_in) begin
          len_d        = stream_len_in;
          run_len_d    = INIT_RUN_L;
          pingpong_d   = 1'b0;
          pass_count_d = '0;
          if (stream_len_in <= INIT_RUN_L) begin
            state_d  = ST_DONE;
            result_d = PONG;
          end else begin
            state_d  = ST_LAUNCH;
            result_d = PING;
          end
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (pass_done_in) begin
          state_d = ST_ADVANCE;
        end
      end
      ST_ADVANCE: begin
        pass_count_d = pass_count_q + PASS_W'(1);
        pingpong_d   = ~pingpong_q;
        run_len_d    = run_next;
        if (run_next >= len_q) begin
          state_d  = ST_DONE;
          result_d = bank_sel_t'(pingpong_q);
        end else begin
          state_d = ST_LAUNCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Flag outputs are decoded from the next state so they register alongside it.
    pass_start_d = (state_d == ST_LAUNCH);
    busy_d       = (state_d == ST_LAUNCH) || (state_d == ST_WAIT) || (state_d == ST_ADVANCE);
    done_d       = (state_d == ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      run_len_q    <= '0;
      pingpong_q   <= 1'b0;
      pass_count_q <= '0;
      result_q     <= PING;
      pass_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      run_len_q    <= run_len_d;
      pingpong_q   <= pingpong_d;
      pass_count_q <= pass_count_d;
      result_q     <= result_d;
      pass_start_q <= pass_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign pass_start_out  = pass_start_q;
  assign run_len_out     = run_len_q;
  assign pingpong_out    = pingpong_q;
  assign busy_out        = busy_q;
  assign done_out        = done_q;
  assign result_bank_out = result_q;
  assign pass_count_out  = pass_count_q;

endmodule

// File: tb/tb_merge_pass_ctrl.sv
// Directed bench for merge_pass_ctrl: multi-pass runs, short streams, ignored events, mid-pass reset.
module tb_merge_pass_ctrl;

  logic        clock;
  logic        reset;
  logic        start_in;
  logic [31:0] stream_len_in;
  logic        pass_done_in;
  logic        pass_start_out;
  logic [31:0] run_len_out;
  logic        pingpong_out;
  logic        busy_out;
  logic        done_out;
  logic        result_bank_out;
  logic [5:0]  pass_count_out;

  int n_cmp = 0;
  int n_err = 0;

  merge_pass_ctrl #(.LEN_W(32), .INIT_RUN(2), .PASS_W(6)) dut (
    .clock           (clock),
    .reset           (reset),
    .start_in        (start_in),
    .stream_len_in   (stream_len_in),
    .pass_done_in    (pass_done_in),
    .pass_start_out  (pass_start_out),
    .run_len_out     (run_len_out),
    .pingpong_out    (pingpong_out),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .result_bank_out (result_bank_out),
    .pass_count_out  (pass_count_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pass_start"}, 32'(pass_start_out), 0);
    check({tag, "_run_len"}, run_len_out, 0);
    check({tag, "_pingpong"}, 32'(pingpong_out), 0);
    check({tag, "_busy"}, 32'(busy_out), 0);
    check({tag, "_done"}, 32'(done_out), 0);
    check({tag, "_result"}, 32'(result_bank_out), 0);
    check({tag, "_pass_count"}, 32'(pass_count_out), 0);
  endtask

  // Called while the DUT is in LAUNCH; returns once it is in the following LAUNCH or DONE.
  task automatic run_pass(input int rl, input int pp, input int cnt, input bit glitch);
    check("launch_pulse", 32'(pass_start_out), 1);
    check("launch_run_len", run_len_out, 32'(rl));
    check("launch_pingpong", 32'(pingpong_out), 32'(pp));
    check("launch_busy", 32'(busy_out), 1);
    check("launch_count", 32'(pass_count_out), 32'(cnt));
    if (glitch) pass_done_in = 1'b1;
    step();
    pass_done_in = 1'b0;
    check("wait_pulse_low", 32'(pass_start_out), 0);
    step();
    step();
    check("wait_pulse_still_low", 32'(pass_start_out), 0);
    check("wait_run_len", run_len_out, 32'(rl));
    check("wait_count", 32'(pass_count_out), 32'(cnt));
    check("wait_busy", 32'(busy_out), 1);
    pass_done_in = 1'b1;
    step();
    pass_done_in = 1'b0;
    check("adv_busy", 32'(busy_out), 1);
    check("adv_run_len", run_len_out, 32'(rl));
    check("adv_pulse_low", 32'(pass_start_out), 0);
    step();
  endtask

  task automatic check_done(input string tag, input int bank, input int cnt);
    check({tag, "_done"}, 32'(done_out), 1);
    check({tag, "_busy"}, 32'(busy_out), 0);
    check({tag, "_pulse"}, 32'(pass_start_out), 0);
    check({tag, "_result"}, 32'(result_bank_out), 32'(bank));
    check({tag, "_count"}, 32'(pass_count_out), 32'(cnt));
  endtask

  task automatic do_start(input int len, input bit with_done);
    start_in      = 1'b1;
    stream_len_in = 32'(len);
    pass_done_in  = with_done;
    step();
    start_in      = 1'b0;
    pass_done_in  = 1'b0;
    stream_len_in = 32'd0;
  endtask

  initial begin
    reset         = 1'b1;
    start_in      = 1'b0;
    stream_len_in = 32'd0;
    pass_done_in  = 1'b0;
    step();
    step();
    reset = 1'b0;
    check_all_zero("reset");

    // Stray pass_done while idle must do nothing.
    pass_done_in = 1'b1;
    step();
    pass_done_in = 1'b0;
    step();
    check_all_zero("idle_done");

    // 8 elements: (2,0) then (4,1), result in PONG.
    do_start(8, 1'b0);
    run_pass(2, 0, 0, 1'b0);
    run_pass(4, 1, 1, 1'b0);
    check_done("len8", 1, 2);
    check("len8_run_len", run_len_out, 8);
    step();
    step();
    check_done("len8_hold", 1, 2);

    // 10 elements with a pass_done in LAUNCH and a start re-pulse during WAIT.
    do_start(10, 1'b0);
    run_pass(2, 0, 0, 1'b1);
    check("len10_p2_pulse", 32'(pass_start_out), 1);
    step();
    start_in      = 1'b1;
    stream_len_in = 32'd4;
    step();
    start_in      = 1'b0;
    stream_len_in = 32'd0;
    check("restart_ignored_pulse", 32'(pass_start_out), 0);
    check("restart_ignored_run_len", run_len_out, 4);
    check("restart_ignored_count", 32'(pass_count_out), 1);
    check("restart_ignored_pp", 32'(pingpong_out), 1);
    pass_done_in = 1'b1;
    step();
    pass_done_in = 1'b0;
    check("len10_adv2_busy", 32'(busy_out), 1);
    step();
    run_pass(8, 0, 2, 1'b0);
    check_done("len10", 0, 3);

    // Short streams: finish immediately without a pass.
    do_start(2, 1'b0);
    check_done("len2", 1, 0);
    step();
    check("len2_busy_later", 32'(busy_out), 0);
    do_start(0, 1'b0);
    check_done("len0", 1, 0);
    step();
    check("len0_busy_later", 32'(busy_out), 0);
    check("len0_pulse_later", 32'(pass_start_out), 0);

    // Restart from DONE with a coincident pass_done, which must be dropped.
    do_start(4, 1'b1);
    run_pass(2, 0, 0, 1'b0);
    check_done("len4", 0, 1);

    // Reset during WAIT of pass 2, then a clean rerun.
    do_start(8, 1'b0);
    run_pass(2, 0, 0, 1'b0);
    step();
    check("rst_in_wait_busy", 32'(busy_out), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_all_zero("mid_reset");
    do_start(8, 1'b0);
    run_pass(2, 0, 0, 1'b0);
    run_pass(4, 1, 1, 1'b0);
    check_done("rerun8", 1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/merge_pass_ctrl.md
# merge_pass_ctrl

Sequences the multi-pass merge sort over the ping/pong memory banks. It starts after the sort phase has left sorted runs of `INIT_RUN` elements in PONG. Each pass, it launches the merge engine with a run length and a bank direction, waits for that pass to complete, then doubles the run length and swaps the banks. It stops once a single run covers the whole stream and reports which bank holds the final result.

## Interface
Parameters:
- `LEN_W`, default 32: width of stream and run lengths.
- `INIT_RUN`, default 2: length of the sorted runs left by the sort phase.
- `PASS_W`, default 6: width of the pass counter.

Ports:
- `clock`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `start_in`  in  1: one-cycle pulse when the sort phase completes.
- `stream_len_in`  in  `LEN_W`: total element count. Sampled only on an accepted `start_in`.
- `pass_done_in`  in  1: one-cycle pulse from the merge engine when the current pass has been fully written.
- `pass_start_out`  out  1: one-cycle pulse that launches a merge pass.
- `run_len_out`  out  `LEN_W`: source run length for the current pass.
- `pingpong_out`  out  1: 1 = read PING, write PONG; 0 = read PONG, write PING.
- `busy_out`  out  1: high from an accepted start until DONE.
- `done_out`  out  1: level, high in DONE.
- `result_bank_out`  out  1: bank holding the sorted stream (0 = PING, 1 = PONG). Valid while `done_out` is high.
- `pass_count_out`  out  `PASS_W`: number of passes completed.

## Operation
- States: IDLE, LAUNCH, WAIT, ADVANCE, DONE.
- IDLE or DONE, with `start_in` high:
  - Latch `stream_len_in`.
  - Set `run_len` to `INIT_RUN`, `pingpong` to 0, `pass_count` to 0; clear `done_out`.
  - If the stream length is ≤ `INIT_RUN` (this includes 0): go to DONE with `result_bank_out` = 1.
  - Otherwise: go to LAUNCH.
- LAUNCH: `pass_start_out` is high for exactly this one cycle. Next state is WAIT.
- WAIT: hold all outputs. On `pass_done_in`, go to ADVANCE.
- ADVANCE:
  - `pass_count` += 1.
  - `pingpong` toggles.
  - `run_len` doubles, saturating at all-ones.
  - If the new `run_len` ≥ the latched stream length: go to DONE with `result_bank_out` = the bank just written (the pre-toggle `pingpong`).
  - Otherwise: go to LAUNCH.
- DONE: all outputs hold until the next `start_in` or `reset`.
- Arithmetic: all comparisons are unsigned at `LEN_W`. The doubling is computed at `LEN_W`+1 bits and saturated back to `LEN_W`. `pass_count` wraps at `PASS_W`; the bench must keep stream lengths small enough that no wrap occurs.
- Ignored events:
  - `start_in` in LAUNCH, WAIT or ADVANCE.
  - `pass_done_in` outside WAIT, including the LAUNCH cycle itself.
  - Simultaneous `start_in` and `pass_done_in` in IDLE or DONE: the start is accepted and the done is dropped.

## Timing
- Reset values: state IDLE; all outputs 0 (`pass_start_out`, `run_len_out`, `pingpong_out`, `busy_out`, `done_out`, `result_bank_out`, `pass_count_out`).
- All outputs are registered; no combinational path from input to output.
- `start_in` sampled in cycle t:
  - LAUNCH, and `pass_start_out` high, in t+1.
  - `busy_out` high from t+1.
  - `run_len_out` and `pingpong_out` valid from t+1 and stable through WAIT.
- `pass_done_in` sampled in cycle k: ADVANCE in k+1; then LAUNCH or DONE in k+2. The next pass's outputs are valid in k+2.
- Per-pass controller overhead is 3 cycles (LAUNCH, ADVANCE, and the cycle that samples done).
- Short stream: `done_out` is high at t+1 and `busy_out` stays 0.
- `reset` asserted mid-pass: state returns to IDLE and outputs clear the next cycle. The merge engine must be reset by the same signal.

## Structure
- Shared package: `bank_sel_t` (`PING`=0, `PONG`=1), the `merge_ctrl_state_t` enum, and the `INIT_RUN` default constant.
- Single flat module; no sub-module is warranted.
- The top level wires `pingpong_out` to the existing merge-phase bank muxing and `start_in` to the sort-done pulse.

## Test plan
- `stream_len`=8, `pass_done` 5 cycles after each start:
  - 2 passes, with (`run_len`, `pingpong`) = (2,0) then (4,1).
  - Ends with `done_out`=1, `result_bank_out`=1, `pass_count_out`=2.
- `stream_len`=10: 3 passes with `run_len` 2, 4, 8; ends with `result_bank_out`=0, `pass_count_out`=3.
- `stream_len`=2 and `stream_len`=0: `done_out` high at t+1, `busy_out` never set, `pass_start_out` never pulses, `result_bank_out`=1.
- `pass_done_in` driven during the LAUNCH cycle and in IDLE: ignored, controller stays in WAIT; a later `pass_done_in` advances normally.
- `start_in` re-pulsed during WAIT: ignored, `run_len_out` and `stream_len` unchanged. A restart from DONE with `stream_len`=4 gives 1 pass and `result_bank_out`=0.
- `reset` in WAIT of pass 2 of an 8-element stream: all outputs 0 next cycle; a fresh start then runs from pass 1 correctly.
